// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter merging REQ requesters onto a single RAM port, with
// read responses routed back to the issuing requester after a fixed latency.
module ram_port_arbiter #(
  parameter int unsigned REQ    = 4,
  parameter int unsigned DATA   = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned OUTREG = 0,
  localparam int unsigned ADDR  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [REQ-1:0]             req_valid,
  input  logic [REQ-1:0]             req_rw_,
  input  logic [REQ-1:0][ADDR-1:0]   req_addr,
  input  logic [REQ-1:0][DATA-1:0]   req_wdata,
  output logic [REQ-1:0]             req_ready,
  output logic [REQ-1:0]             rsp_valid,
  output logic [REQ-1:0][DATA-1:0]   rsp_rdata,
  output logic                       ram_en,
  output logic                       ram_rw_,
  output logic [ADDR-1:0]            ram_addr,
  output logic [DATA-1:0]            ram_wdata,
  input  logic [DATA-1:0]            ram_rdata
);

  localparam int unsigned PTR_W = $clog2(REQ);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_ptr_nxt;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] cand;
  logic [REQ-1:0]   grant;
  logic             grant_any;
  logic             rd_fire;
  logic             tag_vld;
  logic [PTR_W-1:0] tag_idx;
  int unsigned      idx;

  // First valid requester at or after rr_ptr, wrapping modulo REQ.
  always_comb begin
    grant      = '0;
    grant_idx  = '0;
    grant_any  = 1'b0;
    cand       = '0;
    idx        = 0;
    for (int unsigned k = 0; k < REQ; k++) begin
      idx  = (32'(rr_ptr) + k) % REQ;
      cand = PTR_W'(idx);
      if (!grant_any && req_valid[cand]) begin
        grant_any       = 1'b1;
        grant_idx       = cand;
        grant[cand]     = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (grant_any) begin
      rr_ptr_nxt = (grant_idx == PTR_W'(REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_ptr <= '0;
    else        rr_ptr <= rr_ptr_nxt;
  end

  assign req_ready = reset ? grant : '0;
  assign ram_en    = reset & (|req_valid);
  assign ram_rw_   = req_rw_[grant_idx];
  assign ram_addr  = req_addr[grant_idx];
  assign ram_wdata = req_wdata[grant_idx];
  assign rd_fire   = grant_any & req_rw_[grant_idx];

  // With a registered RAM output the tag waits one edge for the data.
  if (OUTREG != 0) begin : g_outreg
    logic             tag_vld_q;
    logic [PTR_W-1:0] tag_idx_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        tag_vld_q <= 1'b0;
        tag_idx_q <= '0;
      end else begin
        tag_vld_q <= rd_fire;
        tag_idx_q <= grant_idx;
      end
    end
    assign tag_vld = tag_vld_q;
    assign tag_idx = tag_idx_q;
  end else begin : g_direct
    assign tag_vld = rd_fire;
    assign tag_idx = grant_idx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      if (tag_vld) begin
        rsp_valid[tag_idx] <= 1'b1;
        rsp_rdata[tag_idx] <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: OUTREG=0 and OUTREG=1 instances share stimulus,
// each with its own RAM model; responses are checked through scoreboards.
module tb_ram_port_arbiter;

  localparam int unsigned REQ   = 4;
  localparam int unsigned DATA  = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned ADDR  = 2;

  typedef struct {
    int             due;
    int             g;
    logic [DATA-1:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [REQ-1:0]           v, rw;
  logic [REQ-1:0][ADDR-1:0] a;
  logic [REQ-1:0][DATA-1:0] wd;

  logic [REQ-1:0]           ready   [2];
  logic [REQ-1:0]           rvalid  [2];
  logic [REQ-1:0][DATA-1:0] rdata_r [2];
  logic                     en      [2];
  logic                     ram_rw  [2];
  logic [ADDR-1:0]          ram_a   [2];
  logic [DATA-1:0]          ram_wd  [2];
  logic [DATA-1:0]          ram_rd  [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ptr      = 0;
  int last_grant = -1;
  logic [DATA-1:0] mm [DEPTH];
  exp_t sb [2][$];

  for (genvar u = 0; u < 2; u++) begin : g_dut
    logic [DATA-1:0] mem [DEPTH];
    logic [DATA-1:0] rd_q;

    ram_port_arbiter #(.REQ(REQ), .DATA(DATA), .DEPTH(DEPTH), .OUTREG(u)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (v),
      .req_rw_   (rw),
      .req_addr  (a),
      .req_wdata (wd),
      .req_ready (ready[u]),
      .rsp_valid (rvalid[u]),
      .rsp_rdata (rdata_r[u]),
      .ram_en    (en[u]),
      .ram_rw_   (ram_rw[u]),
      .ram_addr  (ram_a[u]),
      .ram_wdata (ram_wd[u]),
      .ram_rdata (ram_rd[u])
    );

    // Flip-flop RAM: combinational read, or registered read when OUTREG=1.
    always @(posedge clk) begin
      if (en[u]) begin
        if (!ram_rw[u]) mem[ram_a[u]] <= ram_wd[u];
        else            rd_q <= mem[ram_a[u]];
      end
    end
    assign ram_rd[u] = (u == 1) ? rd_q : mem[ram_a[u]];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: round-robin grant, memory contents, expected responses.
  always @(negedge clk) begin : model
    int g;
    int id;
    logic [REQ-1:0] exp_ready;
    if (!reset) begin
      ptr = 0;
      last_grant = -1;
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("rst_ready%0d", u), 64'(ready[u]), 64'(0));
        chk($sformatf("rst_en%0d", u), 64'(en[u]), 64'(0));
      end
    end else begin
      g = -1;
      for (int k = 0; k < int'(REQ); k++) begin
        id = (ptr + k) % int'(REQ);
        if (g < 0 && v[id]) g = id;
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("ready%0d", u), 64'(ready[u]), 64'(exp_ready));
        chk($sformatf("ram_en%0d", u), 64'(en[u]), 64'(g >= 0));
        if (g >= 0)
          chk($sformatf("ram_req%0d", u), 64'({ram_rw[u], ram_a[u], ram_wd[u]}),
              64'({rw[g], a[g], wd[g]}));
      end
      if (g >= 0) begin
        if (rw[g]) begin
          for (int u = 0; u < 2; u++) sb[u].push_back('{cyc + 1 + u, g, mm[a[g]]});
        end else begin
          mm[a[g]] = wd[g];
        end
        ptr = (g + 1) % int'(REQ);
      end
      last_grant = g;
    end
  end

  // Monitor: compare presented responses with the scoreboard heads.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [REQ-1:0]           ev;
    logic [REQ-1:0][DATA-1:0] ed;
    for (int u = 0; u < 2; u++) begin
      ev = '0;
      ed = '0;
      if (!reset) begin
        sb[u].delete();
      end else if (sb[u].size() > 0 && sb[u][0].due <= cyc) begin
        e = sb[u].pop_front();
        if (e.due == cyc) begin
          ev[e.g] = 1'b1;
          ed[e.g] = e.d;
        end else begin
          chk($sformatf("rsp_late%0d", u), 64'(e.due), 64'(cyc));
        end
      end
      chk($sformatf("rsp_valid%0d", u), 64'(rvalid[u]), 64'(ev));
      chk($sformatf("rsp_rdata%0d", u), 64'(rdata_r[u]), 64'(ed));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (last_grant >= 0) v[last_grant] = 1'b0;
  endtask

  task automatic put(input int r, input logic rd, input int ad, input logic [DATA-1:0] d);
    v[r]  = 1'b1;
    rw[r] = rd;
    a[r]  = ADDR'(ad);
    wd[r] = d;
  endtask

  task automatic put_rand(input int r);
    put(r, 1'($urandom_range(1, 0)), int'($urandom_range(DEPTH - 1, 0)), DATA'($urandom));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((v != '0 || sb[0].size() > 0 || sb[1].size() > 0) && n < 40) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(n < 40), 64'(1));
  endtask

  initial begin
    reset = 1'b0;
    v  = '0;
    rw = '0;
    a  = '0;
    wd = '0;
    // All requesters valid during reset: writes fill every address.
    for (int r = 0; r < int'(REQ); r++) put(r, 1'b0, r, DATA'(16'h1000 + r));
    repeat (3) tick();
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      for (int r = 0; r < int'(REQ); r++) if (!v[r] && i < 7) put_rand(r);
    end
    drain();

    // Write then read-after-write from another requester.
    put(2, 1'b0, 3, 16'h1234);
    tick();
    put(0, 1'b1, 3, '0);
    tick();
    drain();

    // Back-to-back reads from two requesters.
    put(1, 1'b0, 0, 16'hAAAA);
    tick();
    put(1, 1'b0, 1, 16'h5555);
    tick();
    put(1, 1'b1, 0, '0);
    tick();
    put(3, 1'b1, 1, '0);
    tick();
    drain();

    // Continuous req1, then req3 joins.
    for (int i = 0; i < 12; i++) begin
      if (!v[1]) put_rand(1);
      if (i >= 4 && !v[3]) put_rand(3);
      tick();
    end
    drain();

    // Reset while a read is in flight.
    put(0, 1'b1, 2, '0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    put(2, 1'b1, 2, '0);
    tick();
    put(1, 1'b0, 2, 16'hBEEF);
    tick();
    put(3, 1'b1, 2, '0);
    tick();
    drain();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < int'(REQ); r++)
        if (!v[r] && $urandom_range(1, 0) == 1) put_rand(r);
      tick();
    end
    drain();
    repeat (3) tick();
    chk("sb0_empty", 64'(sb[0].size()), 64'(0));
    chk("sb1_empty", 64'(sb[1].size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
